sub_result_sat_accum: RTL



---
 rtl/sub_result_sat_accum.sv | 99 +++++++++
 1 files changed

// File: rtl/sub_result_sat_accum.sv
`default_nettype none
// ============================================================================
// Module   : sub_result_sat_accum
// Brief    : Corrects 8-bit subtractor results using the overflow flag, then
//            sums a fixed-length frame into a saturating signed accumulator
//            and presents each frame total on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module sub_result_sat_accum #(
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       result,
    input  logic             overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat,
    output logic [7:0]       out_ovf_cnt
);

    localparam logic       c_ACCUM = 1'b0;
    localparam logic       c_HOLD  = 1'b1;
    localparam logic [7:0] c_LAST  = 8'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] c_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic             r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [7:0]       r_ovf_cnt;
    logic [7:0]       r_cnt;

    logic             w_accept;
    logic [7:0]       w_sample;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_clamp;

    assign w_accept = in_valid && (r_state == c_ACCUM);

    // A wrapped difference with overflow set has the opposite sign of the true value
    always_comb begin
        w_sample = result;
        if (overflow) begin
            w_sample = result[7] ? 8'h7F : 8'h80;
        end
    end

    assign w_sum = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-7){w_sample[7]}}, w_sample};

    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        w_clamp    = 1'b0;
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_clamp    = 1'b1;
            w_acc_next = w_sum[ACC_W] ? c_MIN : c_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ACCUM;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_ovf_cnt <= '0;
            r_cnt     <= '0;
        end else if (r_state == c_HOLD) begin
            if (out_ready) begin
                r_state   <= c_ACCUM;
                r_acc     <= '0;
                r_sat     <= 1'b0;
                r_ovf_cnt <= '0;
                r_cnt     <= '0;
            end
        end else if (w_accept) begin
            r_acc     <= w_acc_next;
            r_sat     <= r_sat | w_clamp;
            r_ovf_cnt <= r_ovf_cnt + {7'd0, overflow};
            r_cnt     <= r_cnt + 8'd1;
            if (r_cnt == c_LAST) begin
                r_state <= c_HOLD;
            end
        end
    end

    // Outputs come straight from state; out_sum is the running total in ACCUM
    assign in_ready    = (r_state == c_ACCUM) && !rst;
    assign out_valid   = (r_state == c_HOLD);
    assign out_sum     = r_acc;
    assign out_sat     = r_sat;
    assign out_ovf_cnt = r_ovf_cnt;

endmodule
`default_nettype wire
